rr_sel_arb2: RTL and testbench
==============================

# rr_sel_arb2

Two-requester round-robin arbiter that generates the select line for the downstream 2:1 mux and the matching per-channel grants. It sits directly upstream of the mux stage. Each source raises a request. The arbiter picks a winner, drives `sel` so the mux routes that source's `in0`/`in1` data to `out`, and holds the choice until the consumer signals completion or a hold limit forces a hand-over. All outputs are registered, so `sel` is glitch-free at the mux input.

## Interface
- `MAX_HOLD`, default 8: maximum consecutive grant cycles while the other channel is waiting; legal range 2..255.
- `clk` input 1: single clock, rising-edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req0` input 1: channel 0 request (level, held until served).
- `req1` input 1: channel 1 request.
- `done` input 1: one-cycle pulse from consumer; current transfer finished.
- `sel` output 1: mux select; 0 routes in0, 1 routes in1.
- `gnt0` output 1: channel 0 granted.
- `gnt1` output 1: channel 1 granted.
- `busy` output 1: `gnt0 | gnt1`.

## Operation
- States: IDLE, GNT0, GNT1. Internal `last` records the most recent winner. Internal `hold_cnt` has width ceil(log2(MAX_HOLD))+1.
- Reset (asynchronous, `rst_n`=0): state IDLE, `gnt0`=`gnt1`=`busy`=0, `sel`=0, `last`=1 (ch0 wins the first tie), `hold_cnt`=0.
- Arbitration function, used in IDLE and on release:
  - Only one request high: that channel wins.
  - Both high: the channel ≠ `last` wins.
  - None high: go to IDLE.
- IDLE: `gnt0`=`gnt1`=0. `sel` holds its last value; no toggling while idle. Any request starts arbitration.
- GNTx:
  - `gntx`=1, `sel`=x, `hold_cnt` increments each cycle, saturating at MAX_HOLD-1.
  - Release when any of these is true:
    - (a) `done`=1;
    - (b) `reqx`=0;
    - (c) `hold_cnt`=MAX_HOLD-1 and the other request is high.
  - On release, `last`←x and arbitrate with `last`=x. The other channel therefore wins if requesting.
  - If the other channel is not requesting and `reqx` is still high, re-grant x. `hold_cnt` restarts at 0.
- Entry into any GNT state clears `hold_cnt` to 0.
- Grant outputs are one-hot or zero at all times; never both high.
- Simultaneous events:
  - `done` together with timeout in the same cycle is a single release.
  - `done` while in IDLE is ignored.
- Requests dropped during IDLE arbitration before the clock edge are not granted. Only values sampled at the edge count.

## Timing
- Request-to-grant latency is 1 cycle.
  - `req` is sampled high at edge k.
  - `gnt` and `sel` are valid after edge k.
  - The mux `out` reflects the selected input combinationally in the same cycle.
- Release with a waiting requester: the hand-over is direct GNTx→GNTy at the edge where the release condition is sampled. There is zero idle cycles between grants.
  - `sel` and the grants change together on that edge.
  - `gntx` falls on the same edge `gnty` rises.
- Release with no requester: the edge after `done` leads to IDLE, with grants low.
- Timeout: if ch0 is granted at edge k and `req1` is continuously high, `gnt1` rises at edge k+MAX_HOLD. ch0 holds exactly MAX_HOLD cycles.
- Reset mid-grant: grants drop immediately, asynchronously, and `sel`→0. After reset deassertion, the first sampling edge arbitrates fresh with `last`=1.

## Test plan
- Reset then `req0`=1 only: after one edge `gnt0`=1, `sel`=0, `busy`=1. Pulse `done` with `req0` dropped: next edge all grants 0; `sel` stays 0.
- Both requests rise together after reset: `gnt0` first. Pulse `done`: `gnt1`=1, `sel`=1 on the very next edge, with no gap cycle. Repeat `done`: back to ch0 (alternation over 6 transfers: 0,1,0,1,0,1).
- MAX_HOLD=4, `req0` held, `req1` rises 1 cycle after `gnt0`, no `done`: `gnt0` high exactly 4 cycles, then `gnt1` with `sel`=1.
- `req1` alone held with no `done` and no competitor: `gnt1` stays high indefinitely (>20 cycles). No timeout switch occurs and `sel` never glitches.
- Assert `rst_n`=0 mid-GNT1: `gnt1`, `busy`, and `sel` go to 0 before the next clock edge. Release reset with both requests high: ch0 granted first.
- `done` pulses while IDLE with no requests produce no grant and no `sel` change. `gnt0 & gnt1` is never 1 (assertion across all tests).

Source files
------------

// File: rtl/rr_sel_arb2_if.sv
// rr_sel_arb2_if
//   Handshake bundle between two requesters, the consumer and the 2:1 select
//   arbiter.
//   req0, req1 : channel requests (level, held until served)
//   done       : one-cycle completion pulse from the consumer
//   sel        : mux select (0 routes in0, 1 routes in1)
//   gnt0, gnt1 : per-channel grants, one-hot or zero
//   busy       : gnt0 | gnt1
//   modport master drives requests/done, modport slave is the arbiter side.
interface rr_sel_arb2_if;
    logic req0;
    logic req1;
    logic done;
    logic sel;
    logic gnt0;
    logic gnt1;
    logic busy;

    modport master (
        output req0, req1, done,
        input  sel, gnt0, gnt1, busy
    );

    modport slave (
        input  req0, req1, done,
        output sel, gnt0, gnt1, busy
    );
endinterface

// File: rtl/rr_sel_arb2.sv
// rr_sel_arb2
//   Two-requester round-robin arbiter producing the select of a downstream
//   2:1 mux plus matching per-channel grants. A grant is held until the
//   consumer pulses done, the owner drops its request, or the owner has held
//   MAX_HOLD cycles while the other channel waits. All outputs are registered
//   so sel is glitch-free at the mux.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset
//     bus   : rr_sel_arb2_if.slave (req0, req1, done in; sel, gnt0, gnt1, busy out)
//
//   state | meaning
//   IDLE  | no grant; sel keeps its last value
//   GNT0  | channel 0 owns the mux (sel = 0)
//   GNT1  | channel 1 owns the mux (sel = 1)
module rr_sel_arb2 #(
    parameter int MAX_HOLD = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    rr_sel_arb2_if.slave bus
);

    localparam int CW = $clog2(MAX_HOLD) + 1;
    localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            last;
    logic            last_nxt;
    logic [CW-1:0]   hold_cnt;
    logic [CW-1:0]   hold_nxt;
    logic            restart;
    logic            sel_q;
    logic            gnt0_q;
    logic            gnt1_q;
    logic            busy_q;

    // Winner of a fresh arbitration: a lone requester wins, a tie goes to
    // the channel that did not win most recently.
    function automatic state_t arbitrate(input logic r0, input logic r1,
                                         input logic lst);
        state_t res;
        res = IDLE;
        if (r0 && r1)
            res = lst ? GNT0 : GNT1;
        else if (r0)
            res = GNT0;
        else if (r1)
            res = GNT1;
        return res;
    endfunction

    always_comb begin
        state_nxt = state;
        last_nxt  = last;
        restart   = 1'b0;
        hold_nxt  = hold_cnt;
        case (state)
            IDLE: begin
                state_nxt = arbitrate(bus.req0, bus.req1, last);
                restart   = 1'b1;
            end
            GNT0: begin
                if (bus.done || !bus.req0 || (hold_cnt == HOLD_LIM && bus.req1)) begin
                    last_nxt  = 1'b0;
                    state_nxt = arbitrate(bus.req0, bus.req1, 1'b0);
                    restart   = 1'b1;
                end
            end
            GNT1: begin
                if (bus.done || !bus.req1 || (hold_cnt == HOLD_LIM && bus.req0)) begin
                    last_nxt  = 1'b1;
                    state_nxt = arbitrate(bus.req0, bus.req1, 1'b1);
                    restart   = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                restart   = 1'b1;
            end
        endcase
        // Any (re-)entry into a grant restarts the hold count; otherwise it
        // saturates so a late-arriving competitor is served on the next edge.
        if (restart)
            hold_nxt = '0;
        else if (hold_cnt != HOLD_LIM)
            hold_nxt = hold_cnt + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            last     <= 1'b1;
            hold_cnt <= '0;
            sel_q    <= 1'b0;
            gnt0_q   <= 1'b0;
            gnt1_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            state    <= state_nxt;
            last     <= last_nxt;
            hold_cnt <= hold_nxt;
            gnt0_q   <= (state_nxt == GNT0);
            gnt1_q   <= (state_nxt == GNT1);
            busy_q   <= (state_nxt != IDLE);
            // sel only moves when a grant is issued; idle keeps the mux steady.
            if (state_nxt == GNT0)
                sel_q <= 1'b0;
            else if (state_nxt == GNT1)
                sel_q <= 1'b1;
        end
    end

    assign bus.sel  = sel_q;
    assign bus.gnt0 = gnt0_q;
    assign bus.gnt1 = gnt1_q;
    assign bus.busy = busy_q;

endmodule

// File: tb/tb_rr_sel_arb2.sv
// tb_rr_sel_arb2
//   Drives a MAX_HOLD=4 and a default (MAX_HOLD=8) arbiter with identical
//   stimulus. A directed vector table targets the MAX_HOLD=4 instance; every
//   cycle both instances are also compared against an ownership-level
//   reference model.
module tb_rr_sel_arb2;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic r0    = 1'b0;
    logic r1    = 1'b0;
    logic dn    = 1'b0;

    int checks = 0;
    int errors = 0;

    rr_sel_arb2_if if4 ();
    rr_sel_arb2_if if8 ();

    assign if4.req0 = r0;
    assign if4.req1 = r1;
    assign if4.done = dn;
    assign if8.req0 = r0;
    assign if8.req1 = r1;
    assign if8.done = dn;

    rr_sel_arb2 #(.MAX_HOLD(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4.slave));
    rr_sel_arb2                 dut8 (.clk(clk), .rst_n(rst_n), .bus(if8.slave));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // owner: -1 none, else channel index; held: cycles the owner has been
    // granted so far in the current grant.
    int   m_owner [2];
    int   m_last  [2];
    int   m_held  [2];
    logic m_sel   [2];
    int   m_mh    [2] = '{4, 8};

    function automatic int pick(input logic a0, input logic a1, input int lst);
        if (a0 && a1) return (lst == 0) ? 1 : 0;
        if (a0) return 0;
        if (a1) return 1;
        return -1;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 2; i++) begin
            m_owner[i] = -1;
            m_last[i]  = 1;
            m_held[i]  = 0;
            m_sel[i]   = 1'b0;
        end
    endtask

    task automatic m_step();
        int   x;
        logic rx, ry;
        for (int i = 0; i < 2; i++) begin
            if (m_owner[i] < 0) begin
                m_owner[i] = pick(r0, r1, m_last[i]);
                m_held[i]  = (m_owner[i] >= 0) ? 1 : 0;
            end else begin
                x  = m_owner[i];
                rx = (x == 1) ? r1 : r0;
                ry = (x == 1) ? r0 : r1;
                if (dn || !rx || (m_held[i] >= m_mh[i] && ry)) begin
                    m_last[i]  = x;
                    m_owner[i] = pick(r0, r1, x);
                    m_held[i]  = (m_owner[i] >= 0) ? 1 : 0;
                end else begin
                    m_held[i]++;
                end
            end
            if (m_owner[i] >= 0) m_sel[i] = (m_owner[i] == 1);
        end
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) m_reset();
            else        m_step();
        end
    end

    task automatic cmp(input string tag, input int i, input logic g0,
                       input logic g1, input logic s, input logic b);
        chk({tag, "_gnt0"}, g0, m_owner[i] == 0);
        chk({tag, "_gnt1"}, g1, m_owner[i] == 1);
        chk({tag, "_sel"},  s,  m_sel[i]);
        chk({tag, "_busy"}, b,  m_owner[i] >= 0);
        checks++;
        onehot: assert (!(g0 === 1'b1 && g1 === 1'b1)) else begin
            errors++;
            $display("FAIL %s_onehot: gnt0=%b gnt1=%b both high", tag, g0, g1);
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            cmp("mh4", 0, if4.gnt0, if4.gnt1, if4.sel, if4.busy);
            cmp("mh8", 1, if8.gnt0, if8.gnt1, if8.sel, if8.busy);
        end
    end

    // ---------------- directed vectors (MAX_HOLD=4 instance) ----------------
    typedef struct {
        logic r0, r1, d;
        logic g0, g1, s;
    } vec_t;

    localparam logic O = 1'b0;
    localparam logic I = 1'b1;
    localparam int NV = 29;
    vec_t tbl [NV];

    initial begin
        //        r0 r1 d   g0 g1 s
        tbl = '{
            '{I, O, O,  I, O, O},   //  0 lone req0 after reset
            '{O, O, I,  O, O, O},   //  1 done + drop -> idle, sel stays 0
            '{I, I, O,  O, I, I},   //  2 tie, last=0 -> ch1
            '{I, I, I,  I, O, O},   //  3 done -> direct hand-over
            '{I, I, I,  O, I, I},   //  4
            '{I, I, I,  I, O, O},   //  5 ch0 granted here
            '{I, I, O,  I, O, O},   //  6 hold
            '{I, I, O,  I, O, O},   //  7
            '{I, I, O,  I, O, O},   //  8 fourth grant cycle
            '{I, I, O,  O, I, I},   //  9 timeout -> ch1
            '{O, I, O,  O, I, I},   // 10 lone req1, no timeout
            '{O, I, O,  O, I, I},   // 11
            '{O, I, O,  O, I, I},   // 12
            '{O, I, O,  O, I, I},   // 13 counter saturated
            '{O, I, O,  O, I, I},   // 14
            '{O, I, O,  O, I, I},   // 15
            '{I, I, O,  I, O, O},   // 16 competitor after saturation -> immediate
            '{I, O, I,  I, O, O},   // 17 done, no competitor -> re-grant ch0
            '{O, O, O,  O, O, O},   // 18 req dropped -> idle
            '{O, O, I,  O, O, O},   // 19 done in idle ignored
            '{O, I, O,  O, I, I},   // 20 lone req1
            '{O, O, O,  O, O, I},   // 21 idle, sel holds 1
            '{O, O, I,  O, O, I},   // 22 done in idle, sel holds
            '{I, I, I,  I, O, O},   // 23 tie, last=1 -> ch0
            '{I, I, O,  I, O, O},   // 24
            '{I, I, O,  I, O, O},   // 25
            '{I, I, O,  I, O, O},   // 26
            '{I, I, I,  O, I, I},   // 27 done with timeout: single release
            '{I, I, O,  O, I, I}    // 28
        };

        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int v = 0; v < NV; v++) begin
            @(negedge clk);
            r0 = tbl[v].r0;
            r1 = tbl[v].r1;
            dn = tbl[v].d;
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_gnt0", v), if4.gnt0, tbl[v].g0);
            chk($sformatf("vec%0d_gnt1", v), if4.gnt1, tbl[v].g1);
            chk($sformatf("vec%0d_sel",  v), if4.sel,  tbl[v].s);
            chk($sformatf("vec%0d_busy", v), if4.busy, tbl[v].g0 | tbl[v].g1);
        end

        // lone req1 held long: no switch, no sel movement on either instance
        @(negedge clk);
        r0 = 1'b0; r1 = 1'b1; dn = 1'b0;
        for (int c = 0; c < 25; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("long%0d_mh8_gnt1", c), if8.gnt1, 1'b1);
            chk($sformatf("long%0d_mh8_sel",  c), if8.sel,  1'b1);
            chk($sformatf("long%0d_mh4_gnt1", c), if4.gnt1, 1'b1);
        end

        // asynchronous reset in the middle of a grant
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mh4_gnt1", if4.gnt1, 1'b0);
        chk("rst_mh4_busy", if4.busy, 1'b0);
        chk("rst_mh4_sel",  if4.sel,  1'b0);
        chk("rst_mh8_gnt1", if8.gnt1, 1'b0);
        chk("rst_mh8_sel",  if8.sel,  1'b0);
        @(negedge clk);
        r0 = 1'b1; r1 = 1'b1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("post_rst_mh4_gnt0", if4.gnt0, 1'b1);
        chk("post_rst_mh4_sel",  if4.sel,  1'b0);
        chk("post_rst_mh8_gnt0", if8.gnt0, 1'b1);
        chk("post_rst_mh8_gnt1", if8.gnt1, 1'b0);

        // random traffic, checked by the model every cycle
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if ($urandom_range(3) == 0) r0 = ~r0;
            if ($urandom_range(3) == 0) r1 = ~r1;
            dn = ($urandom_range(4) == 0);
        end

        @(negedge clk);
        r0 = 1'b0; r1 = 1'b0; dn = 1'b0;
        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
